fetch_stage: RTL and testbench

// Instruction-fetch front end. Generates sequential PCs, issues in-order requests to the

---
 rtl/fetch_stage.sv | 167 ++++++++++++++++
 tb/tb_fetch_stage.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction-fetch front end. Issues sequential, word-aligned fetch requests,
// tracks each request's PC in a small in-flight FIFO, pairs returning words with
// their PCs in an output FIFO, and presents the head entry to decode through a
// valid/stall handshake. A redirect flushes everything and restarts at a new PC.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   imem_req_valid    fetch request valid (out)
//   imem_req_ready    memory accepts the request this cycle (in)
//   imem_req_addr     word-aligned fetch address (out)
//   imem_rsp_valid    response valid, returned in request order (in)
//   imem_rsp_data     instruction word of the response (in)
//   redirect_valid    flush and restart fetch at redirect_pc (in)
//   redirect_pc       restart PC, low two bits ignored (in)
//   out_valid         (out_pc, out_instr) valid toward decode (out)
//   out_pc, out_instr PC and word of the presented instruction (out)
//   stall             decode cannot accept this cycle (in)
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        stall
);

  localparam int          AW      = $clog2(BUF_DEPTH);
  localparam int          CW      = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(BUF_DEPTH);

  logic [31:0]   pc_q;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;

  logic [AW-1:0] pq_rd;
  logic [AW-1:0] pq_wr;
  logic [31:0]   pq_pc [BUF_DEPTH];

  logic [AW-1:0] of_rd;
  logic [AW-1:0] of_wr;
  logic [31:0]   of_pc    [BUF_DEPTH];
  logic [31:0]   of_instr [BUF_DEPTH];

  logic [CW:0]   credits_used;
  logic          accept;
  logic          dropping;
  logic          push;
  logic          pop;
  logic          unused_redirect_bits;

  // The low PC bits of a redirect are forced to zero, so they are never read.
  assign unused_redirect_bits = ^redirect_pc[1:0];

  assign imem_req_addr = pc_q;
  assign out_valid     = (fifo_count != '0);
  assign out_pc        = of_pc[of_rd];
  assign out_instr     = of_instr[of_rd];

  // Credit check counts both in-flight requests and buffered words, so every
  // response is guaranteed a free output slot. Requests pause in a redirect
  // cycle and while reset is held.
  always_comb begin
    credits_used   = {1'b0, outstanding} + {1'b0, fifo_count};
    imem_req_valid = rst && (credits_used < DEPTH_W) && !redirect_valid;
    accept         = imem_req_valid && imem_req_ready;
    dropping       = (drop_cnt != '0);
    push           = imem_rsp_valid && !dropping && !redirect_valid;
    pop            = out_valid && !stall && !redirect_valid;
  end

  // Fetch PC: advances on each accepted request, jumps on redirect.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= {redirect_pc[31:2], 2'b00};
    end else if (accept) begin
      pc_q <= pc_q + 32'd4;
    end
  end

  // Outstanding counts every request still owed a response, including those
  // already marked for dropping. A redirect therefore condemns exactly the
  // outstanding responses minus one consumed in the redirect cycle; any earlier
  // drop residual is already contained in that count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        drop_cnt <= outstanding - CW'(imem_rsp_valid);
      end else if (imem_rsp_valid && dropping) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  // PC FIFO: remembers the address of each live request until its word returns.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pq_rd <= '0;
      pq_wr <= '0;
    end else if (redirect_valid) begin
      pq_rd <= '0;
      pq_wr <= '0;
    end else begin
      if (accept) begin
        pq_pc[pq_wr] <= pc_q;
        pq_wr        <= pq_wr + AW'(1);
      end
      if (push) begin
        pq_rd <= pq_rd + AW'(1);
      end
    end
  end

  // Output FIFO: registered, so a word pushed at an edge is presented only
  // after that edge, even when the FIFO was empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      of_rd      <= '0;
      of_wr      <= '0;
      fifo_count <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        of_pc[i]    <= '0;
        of_instr[i] <= '0;
      end
    end else if (redirect_valid) begin
      of_rd      <= '0;
      of_wr      <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        of_pc[of_wr]    <= pq_pc[pq_rd];
        of_instr[of_wr] <= imem_rsp_data;
        of_wr           <= of_wr + AW'(1);
      end
      if (pop) begin
        of_rd <= of_rd + AW'(1);
      end
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  // Occupancy sanity: neither count may ever exceed the buffer depth.
  always @(posedge clk) begin
    if (rst) begin
      assert (outstanding <= CW'(BUF_DEPTH));
      assert (fifo_count <= CW'(BUF_DEPTH));
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
// Self-checking bench for fetch_stage. A behavioural memory answers requests in
// order after a programmable latency; a stream monitor expects decode to see
// consecutive PCs (restarting at every redirect or reset) carrying the memory's
// word for that PC, and expects a stalled entry to stay put.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'hFFFF_FFF8;
  localparam int          BUF_DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        stall;

  int          checks;
  int          errors;

  int          cyc;
  int          mem_lat;
  logic [31:0] q_addr[$];
  int          q_due[$];
  logic        acc;
  logic [31:0] acc_addr;

  logic [31:0] xfer_log[$];
  logic [31:0] expect_pc;
  logic        hold_v;
  logic [31:0] hold_pc;
  logic [31:0] hold_instr;

  fetch_stage #(
    .RESET_PC (RESET_PC),
    .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .stall         (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Contents of instruction memory: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'hDEAD_BEEF;
  endfunction

  // Advance to just after the next rising edge; inputs are driven from here.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Memory model: requests accepted at an edge are answered in order, the
  // earliest in the cycle right after acceptance when mem_lat is 1.
  initial begin
    cyc            = 0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      acc      = imem_req_valid && imem_req_ready;
      acc_addr = imem_req_addr;
      @(posedge clk);
      cyc++;
      #1;
      if (rst !== 1'b1) begin
        q_addr.delete();
        q_due.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end else begin
        if (acc === 1'b1) begin
          q_addr.push_back(acc_addr);
          q_due.push_back(cyc + mem_lat - 1);
        end
        if (q_addr.size() > 0 && q_due[0] <= cyc) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(q_addr[0]);
          void'(q_addr.pop_front());
          void'(q_due.pop_front());
        end else begin
          imem_rsp_valid = 1'b0;
          imem_rsp_data  = $urandom;
        end
      end
    end
  end

  // Stream monitor: every transfer must be the next sequential PC with its
  // memory word; a stalled entry must be presented unchanged next cycle.
  initial begin
    hold_v     = 1'b0;
    hold_pc    = '0;
    hold_instr = '0;
    expect_pc  = RESET_PC;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        expect_pc = RESET_PC;
        hold_v    = 1'b0;
      end else begin
        if (hold_v) begin
          checks++;
          if (out_valid !== 1'b1 || out_pc !== hold_pc || out_instr !== hold_instr) begin
            errors++;
            $display("[TB] FAIL stall_hold got valid=%b pc=%h instr=%h want valid=1 pc=%h instr=%h",
                     out_valid, out_pc, out_instr, hold_pc, hold_instr);
          end
        end
        if (redirect_valid === 1'b1) begin
          expect_pc = {redirect_pc[31:2], 2'b00};
          hold_v    = 1'b0;
        end else begin
          if (out_valid === 1'b1 && stall === 1'b0) begin
            checks++;
            if (out_pc !== expect_pc) begin
              errors++;
              $display("[TB] FAIL stream_pc got %h want %h", out_pc, expect_pc);
            end
            checks++;
            if (out_instr !== mem_word(expect_pc)) begin
              errors++;
              $display("[TB] FAIL stream_instr got %h want %h", out_instr, mem_word(expect_pc));
            end
            xfer_log.push_back(out_pc);
            expect_pc = expect_pc + 32'd4;
          end
          hold_v     = (out_valid === 1'b1) && (stall === 1'b1);
          hold_pc    = out_pc;
          hold_instr = out_instr;
        end
      end
    end
  end

  // Reset state, first request on release, and PC wrap from the reset PC.
  task automatic test_reset();
    int n;
    $display("[TB] test_reset");
    rst = 1'b0;
    repeat (3) tick();
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_req_valid got %b want 0", imem_req_valid);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (out_pc !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_out_pc got %h want 00000000", out_pc);
    end
    checks++;
    if (out_instr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_out_instr got %h want 00000000", out_instr);
    end
    n   = xfer_log.size();
    rst = 1'b1;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
      errors++;
      $display("[TB] FAIL first_req got valid=%b addr=%h want valid=1 addr=%h",
               imem_req_valid, imem_req_addr, RESET_PC);
    end
    for (int i = 0; i < 30 && xfer_log.size() < n + 3; i++) tick();
    checks++;
    if (xfer_log.size() < n + 3) begin
      errors++;
      $display("[TB] FAIL wrap_timeout got %0d transfers want 3", xfer_log.size() - n);
    end else if (xfer_log[n] !== 32'hFFFF_FFF8 || xfer_log[n+1] !== 32'hFFFF_FFFC ||
                 xfer_log[n+2] !== 32'h0000_0000) begin
      errors++;
      $display("[TB] FAIL wrap_seq got %h %h %h want fffffff8 fffffffc 00000000",
               xfer_log[n], xfer_log[n+1], xfer_log[n+2]);
    end
  endtask

  // Free-running fetch: with depth 2 and 1-cycle memory, two words per three cycles.
  task automatic test_sequential();
    int n;
    $display("[TB] test_sequential");
    stall = 1'b0; imem_req_ready = 1'b1; mem_lat = 1;
    n = xfer_log.size();
    repeat (30) tick();
    checks++;
    if (xfer_log.size() - n < 18) begin
      errors++;
      $display("[TB] FAIL seq_rate got %0d transfers want >=18", xfer_log.size() - n);
    end
  endtask

  // Hold stall until full: outputs frozen, no requests; release drains two back to back.
  task automatic test_stall();
    logic [31:0] p;
    logic [31:0] pi;
    $display("[TB] test_stall");
    stall = 1'b1;
    repeat (6) tick();
    #1;
    p  = out_pc;
    pi = out_instr;
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== p || out_instr !== pi) begin
        errors++;
        $display("[TB] FAIL stall_stable got valid=%b pc=%h instr=%h want 1 %h %h",
                 out_valid, out_pc, out_instr, p, pi);
      end
      checks++;
      if (imem_req_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_full_req got %b want 0", imem_req_valid);
      end
    end
    tick();
    stall = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== p || imem_req_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drain_first got valid=%b pc=%h req=%b want 1 %h 0",
               out_valid, out_pc, imem_req_valid, p);
    end
    tick();
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== p + 32'd4 || imem_req_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL drain_second got valid=%b pc=%h req=%b want 1 %h 1",
               out_valid, out_pc, imem_req_valid, p + 32'd4);
    end
  endtask

  // Memory back-pressure: the request address must not move while unaccepted.
  task automatic test_ready_hold();
    logic [31:0] a0;
    $display("[TB] test_ready_hold");
    repeat (4) tick();
    tick();
    imem_req_ready = 1'b0;
    #1;
    a0 = imem_req_addr;
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      checks++;
      if (imem_req_addr !== a0) begin
        errors++;
        $display("[TB] FAIL addr_hold got %h want %h", imem_req_addr, a0);
      end
    end
    checks++;
    if (imem_req_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_req_valid got %b want 1", imem_req_valid);
    end
    tick();
    imem_req_ready = 1'b1;
    repeat (8) tick();
  endtask

  // Redirect with two requests in flight: both late words are discarded.
  task automatic test_redirect_inflight();
    int n;
    logic found;
    $display("[TB] test_redirect_inflight");
    mem_lat = 3;
    found   = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      #1;
      if (q_addr.size() == 2) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL inflight_setup got 0 want 1");
    end
    n              = xfer_log.size();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL redirect_no_req got %b want 0", imem_req_valid);
    end
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (imem_req_addr !== 32'h0000_0100) begin
      errors++;
      $display("[TB] FAIL redirect_addr got %h want 00000100", imem_req_addr);
    end
    for (int i = 0; i < 40 && xfer_log.size() < n + 2; i++) tick();
    checks++;
    if (xfer_log.size() < n + 2) begin
      errors++;
      $display("[TB] FAIL inflight_timeout got %0d transfers want 2", xfer_log.size() - n);
    end else if (xfer_log[n] !== 32'h100 || xfer_log[n+1] !== 32'h104) begin
      errors++;
      $display("[TB] FAIL inflight_seq got %h %h want 00000100 00000104", xfer_log[n], xfer_log[n+1]);
    end
  endtask

  // Redirect colliding with a response and a pop, then another redirect next cycle.
  task automatic test_redirect_b2b();
    int n;
    logic found;
    $display("[TB] test_redirect_b2b");
    mem_lat = 1;
    found   = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      #1;
      if (imem_rsp_valid === 1'b1 && out_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL b2b_setup got 0 want 1");
    end
    n              = xfer_log.size();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0180;
    tick();
    redirect_pc    = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 40 && xfer_log.size() < n + 2; i++) tick();
    checks++;
    if (xfer_log.size() < n + 2) begin
      errors++;
      $display("[TB] FAIL b2b_timeout got %0d transfers want 2", xfer_log.size() - n);
    end else if (xfer_log[n] !== 32'h200 || xfer_log[n+1] !== 32'h204) begin
      errors++;
      $display("[TB] FAIL b2b_seq got %h %h want 00000200 00000204", xfer_log[n], xfer_log[n+1]);
    end
  endtask

  // Reset in the middle of traffic restarts the stream at the reset PC.
  task automatic test_mid_reset();
    int n;
    $display("[TB] test_mid_reset");
    mem_lat = 2;
    repeat (5) tick();
    rst = 1'b0;
    tick();
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs got req=%b valid=%b pc=%h instr=%h want 0 0 0 0",
               imem_req_valid, out_valid, out_pc, out_instr);
    end
    n   = xfer_log.size();
    rst = 1'b1;
    for (int i = 0; i < 30 && xfer_log.size() <= n; i++) tick();
    checks++;
    if (xfer_log.size() <= n) begin
      errors++;
      $display("[TB] FAIL midreset_timeout got 0 transfers want 1");
    end else if (xfer_log[n] !== RESET_PC) begin
      errors++;
      $display("[TB] FAIL midreset_first_pc got %h want %h", xfer_log[n], RESET_PC);
    end
  endtask

  // Random stall, back-pressure, latency and redirects; the monitor checks the stream.
  task automatic test_random();
    int n;
    $display("[TB] test_random");
    n = xfer_log.size();
    for (int i = 0; i < 400; i++) begin
      tick();
      stall          = ($urandom_range(0, 9) < 3);
      imem_req_ready = ($urandom_range(0, 9) < 7);
      mem_lat        = $urandom_range(1, 4);
      if ($urandom_range(0, 99) < 4) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom;
      end else begin
        redirect_valid = 1'b0;
      end
    end
    tick();
    redirect_valid = 1'b0;
    stall          = 1'b0;
    imem_req_ready = 1'b1;
    repeat (20) tick();
    checks++;
    if (xfer_log.size() - n < 40) begin
      errors++;
      $display("[TB] FAIL random_progress got %0d transfers want >=40", xfer_log.size() - n);
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b0;
    stall          = 1'b0;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_lat        = 1;
    test_reset();
    test_sequential();
    test_stall();
    test_ready_hold();
    test_redirect_inflight();
    test_redirect_b2b();
    test_mid_reset();
    test_random();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
